// File: rtl/fm_sb_playback.sv
// fm_sb_playback: AXI-loaded pattern memory replayed as a valid/ready stream into the datapath
module fm_sb_playback #(
    parameter int TP_DW  = 51,
    parameter int AXI_DW = 32,
    parameter int SB_DW  = 64,
    parameter int DEPTH  = 256,
    parameter int WPE    = SB_DW / AXI_DW,
    parameter int WSEL_W = (WPE > 1) ? $clog2(WPE) : 1,
    parameter int ADDR_W = $clog2(DEPTH) + WSEL_W,
    parameter int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [AXI_DW-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [AXI_DW-1:0] rd_data,
    output logic              rd_vld,
    input  logic [1:0]        pb_mode,
    input  logic              pb_start,
    input  logic [LEN_W-1:0]  pb_len,
    input  logic              pb_ready,
    output logic [TP_DW-1:0]  pb_data,
    output logic              pb_vld,
    output logic              pb_busy,
    output logic              pb_done,
    output logic [15:0]       pb_loop_cnt
);
    localparam int EW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [WPE-1:0][AXI_DW-1:0] mem [DEPTH];

    state_t                  state_q, state_d;
    logic                    loop_q, loop_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [EW-1:0]           ptr_q, ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    hd_q, hd_d;
    logic [1:0][TP_DW-1:0]   fd_q, fd_d;
    logic [1:0]              fl_q, fl_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             lcnt_q, lcnt_d;
    logic [AXI_DW-1:0]       rd_data_q, rd_data_d;
    logic                    rd_vld_q, rd_vld_d;

    logic [EW-1:0]     wr_ent, rd_ent;
    logic [WSEL_W-1:0] wr_sel, rd_sel;
    logic              wr_ok, rd_ok;
    logic              go, abort, pop, fetch, last, wslot;
    logic [LEN_W-1:0]  len_clamp;

    assign wr_ent    = wr_addr[ADDR_W-1:WSEL_W];
    assign wr_sel    = wr_addr[WSEL_W-1:0];
    assign rd_ent    = rd_addr[ADDR_W-1:WSEL_W];
    assign rd_sel    = rd_addr[WSEL_W-1:0];
    assign wr_ok     = 32'(wr_sel) < WPE;
    assign rd_ok     = 32'(rd_sel) < WPE;
    assign go        = pb_mode == 2'b01 || pb_mode == 2'b10;
    assign abort     = state_q != IDLE && !go;
    assign pb_vld    = cnt_q != 2'd0;
    assign pop       = pb_vld && pb_ready;
    // A slot frees up in the same cycle the head is accepted, so fetching continues at full rate.
    assign fetch     = state_q == RUN && (cnt_q != 2'd2 || pop);
    assign last      = {1'b0, ptr_q} == len_q - LEN_W'(1);
    assign wslot     = hd_q ^ cnt_q[0];
    assign len_clamp = pb_len > LEN_W'(DEPTH) ? LEN_W'(DEPTH) : pb_len;

    assign pb_data     = pb_vld ? fd_q[hd_q] : '0;
    assign pb_busy     = busy_q;
    assign pb_done     = done_q;
    assign pb_loop_cnt = lcnt_q;
    assign rd_data     = rd_data_q;
    assign rd_vld      = rd_vld_q;

    // Word-granular memory write; reads elsewhere see the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) mem[wr_ent][wr_sel] <= wr_data;
    end

    // AXI readback word selection; out-of-range word selects read as zero.
    always_comb begin
        rd_vld_d  = rd_en;
        rd_data_d = rd_en ? (rd_ok ? mem[rd_ent][rd_sel] : '0) : rd_data_q;
    end

    // Playback sequencing, 2-entry output buffer and status next-state.
    always_comb begin
        state_d = state_q;
        loop_d  = loop_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        fd_d    = fd_q;
        fl_d    = fl_q;
        done_d  = 1'b0;
        hd_d    = pop ? ~hd_q : hd_q;
        cnt_d   = cnt_q + 2'(fetch) - 2'(pop);
        lcnt_d  = (pop && loop_q && fl_q[hd_q] && lcnt_q != 16'hFFFF) ? lcnt_q + 16'd1 : lcnt_q;
        if (fetch) begin
            fd_d[wslot] = TP_DW'(mem[ptr_q]);
            fl_d[wslot] = last;
            ptr_d       = last ? '0 : ptr_q + EW'(1);
        end
        case (state_q)
            IDLE: begin
                if (pb_start && go) begin
                    loop_d  = pb_mode[1];
                    len_d   = len_clamp;
                    lcnt_d  = '0;
                    ptr_d   = '0;
                    state_d = pb_len == '0 ? IDLE : RUN;
                    done_d  = pb_len == '0 && !pb_mode[1];
                end
            end
            RUN:     state_d = (fetch && last && !loop_q) ? DRAIN : RUN;
            DRAIN: begin
                if (pop && cnt_q == 2'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
        busy_d = !abort && (state_d != IDLE || state_q != IDLE);
    end

    // State registers with synchronous reset; buffered playback data is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            loop_q    <= 1'b0;
            len_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            hd_q      <= 1'b0;
            fd_q      <= '0;
            fl_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lcnt_q    <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            loop_q    <= loop_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            hd_q      <= hd_d;
            fd_q      <= fd_d;
            fl_q      <= fl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lcnt_q    <= lcnt_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end
endmodule

// File: tb/tb_fm_sb_playback.sv
// tb_fm_sb_playback: directed and randomized checks of fm_sb_playback against a memory-array reference model
module tb_fm_sb_playback;
    localparam int TP_DW  = 51;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [31:0]       rd_data;
    logic              rd_vld;
    logic [1:0]        pb_mode = 2'b00;
    logic              pb_start = 1'b0;
    logic [LEN_W-1:0]  pb_len = '0;
    logic              pb_ready = 1'b0;
    logic [TP_DW-1:0]  pb_data;
    logic              pb_vld;
    logic              pb_busy;
    logic              pb_done;
    logic [15:0]       pb_loop_cnt;

    int checks = 0;
    int failures = 0;
    logic [63:0] model [DEPTH];

    always #5 clk = ~clk;

    fm_sb_playback dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
        .pb_mode(pb_mode), .pb_start(pb_start), .pb_len(pb_len), .pb_ready(pb_ready),
        .pb_data(pb_data), .pb_vld(pb_vld), .pb_busy(pb_busy), .pb_done(pb_done),
        .pb_loop_cnt(pb_loop_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pay(input int e);
        return 64'(model[e][TP_DW-1:0]);
    endfunction

    task automatic wr(input int e, input int w, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(e * 2 + w);
        wr_data = d;
        tick;
        wr_en = 1'b0;
        model[e][w*32 +: 32] = d;
    endtask

    task automatic rd_chk(input int e, input int w, input string tag);
        rd_en = 1'b1;
        rd_addr = ADDR_W'(e * 2 + w);
        tick;
        rd_en = 1'b0;
        chk({tag, " rd_vld"}, 64'(rd_vld), 64'd1);
        chk({tag, " rd_data"}, 64'(rd_data), 64'(model[e][w*32 +: 32]));
    endtask

    // ntrans==0: run a single pass to pb_done; ntrans>0: abort right after that many transfers.
    task automatic play(input logic [1:0] mode, input int plen, input int elen, input int ntrans,
                        input int rk, input string tag);
        int got = 0;
        int dones = 0;
        int lasts = 0;
        int k = 0;
        int cyc = 0;
        bit ended = 0;
        logic held = 1'b0;
        logic [TP_DW-1:0] hold = '0;
        pb_mode = mode;
        pb_len = LEN_W'(plen);
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        while (!ended && cyc < 4000) begin
            pb_ready = rk == 0 ? 1'b1 : (rk == 1 ? (k % 3 == 0) : ($urandom_range(0, 2) != 0));
            k++;
            if (held) chk({tag, " hold"}, {pb_vld, pb_data}, {1'b1, hold});
            if (pb_done) dones++;
            if (pb_vld && pb_ready) begin
                chk({tag, " data"}, 64'(pb_data), pay(got % elen));
                if (got % elen == elen - 1) lasts++;
                got++;
            end
            held = pb_vld && !pb_ready;
            hold = pb_data;
            if (ntrans == 0 && pb_done) begin
                ended = 1;
            end else if (ntrans > 0 && got == ntrans) begin
                pb_mode = 2'b00;
                tick;
                ended = 1;
            end else begin
                tick;
                cyc++;
            end
        end
        chk({tag, " ended"}, 64'(ended), 64'd1);
        if (ntrans == 0) begin
            chk({tag, " count"}, 64'(got), 64'(elen));
            chk({tag, " dones"}, 64'(dones), 64'd1);
            chk({tag, " vld@done"}, 64'(pb_vld), 64'd0);
            chk({tag, " busy@done"}, 64'(pb_busy), 64'd1);
            chk({tag, " loopcnt"}, 64'(pb_loop_cnt), 64'd0);
            tick;
            chk({tag, " busy after"}, 64'(pb_busy), 64'd0);
        end else begin
            chk({tag, " abort vld"}, 64'(pb_vld), 64'd0);
            chk({tag, " abort busy"}, 64'(pb_busy), 64'd0);
            chk({tag, " abort done"}, 64'(pb_done | (dones != 0)), 64'd0);
            chk({tag, " loopcnt"}, 64'(pb_loop_cnt), mode == 2'b10 ? 64'(lasts) : 64'd0);
            tick;
            chk({tag, " no late done"}, 64'(pb_done), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] oldv;
        logic [31:0] neww;
        tick;
        tick;
        chk("reset pb_vld", 64'(pb_vld), 64'd0);
        chk("reset pb_busy", 64'(pb_busy), 64'd0);
        chk("reset pb_done", 64'(pb_done), 64'd0);
        chk("reset loopcnt", 64'(pb_loop_cnt), 64'd0);
        chk("reset pb_data", 64'(pb_data), 64'd0);
        chk("reset rd_vld", 64'(rd_vld), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        for (int e = 0; e < DEPTH; e++)
            for (int w = 0; w < 2; w++) wr(e, w, $urandom);
        wr(0, 0, 32'hDEADBEEF);
        wr(0, 1, 32'h00000001);
        rd_chk(0, 0, "t1 w0");
        rd_chk(0, 1, "t1 w1");
        tick;
        chk("t1 rd_vld drop", 64'(rd_vld), 64'd0);
        play(2'b01, 1, 1, 0, 0, "t1 pb");
        for (int i = 0; i < 4; i++) begin
            wr(i, 0, 32'(i + 1));
            wr(i, 1, 32'd0);
        end
        pb_mode = 2'b01;
        pb_len = 9'd4;
        pb_ready = 1'b1;
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        chk("t2 T+1 busy", 64'(pb_busy), 64'd1);
        chk("t2 T+1 vld", 64'(pb_vld), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2 vld", 64'(pb_vld), 64'd1);
            chk("t2 data", 64'(pb_data), 64'(i + 1));
            chk("t2 no done", 64'(pb_done), 64'd0);
        end
        tick;
        chk("t2 T+6 done", 64'(pb_done), 64'd1);
        chk("t2 T+6 vld", 64'(pb_vld), 64'd0);
        chk("t2 T+6 busy", 64'(pb_busy), 64'd1);
        tick;
        chk("t2 T+7 done", 64'(pb_done), 64'd0);
        chk("t2 T+7 busy", 64'(pb_busy), 64'd0);
        play(2'b01, 4, 4, 0, 1, "t3 bp");
        wr(0, 0, 32'd7);
        wr(1, 0, 32'd8);
        wr(2, 0, 32'd9);
        play(2'b10, 3, 3, 10, 0, "t4 loop");
        play(2'b01, 4, 4, 2, 0, "t5 abort");
        pb_mode = 2'b01;
        pb_len = '0;
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        chk("t5 len0 done", 64'(pb_done), 64'd1);
        chk("t5 len0 vld", 64'(pb_vld), 64'd0);
        tick;
        chk("t5 len0 done off", 64'(pb_done), 64'd0);
        chk("t5 len0 vld2", 64'(pb_vld), 64'd0);
        pb_mode = 2'b10;
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        chk("t5 loop len0 done", 64'(pb_done), 64'd0);
        chk("t5 loop len0 vld", 64'(pb_vld), 64'd0);
        tick;
        play(2'b01, 300, DEPTH, 0, 0, "clamp");
        for (int r = 0; r < 6; r++) begin
            int l;
            l = $urandom_range(1, 40);
            play(2'b01, l, l, 0, 2, "rand single");
            l = $urandom_range(1, 40);
            play(2'b10, l, l, $urandom_range(1, 100), 2, "rand loop");
        end
        pb_mode = 2'b10;
        pb_len = 9'd5;
        pb_ready = 1'b1;
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        rst = 1'b1;
        tick;
        chk("t6 rst vld", 64'(pb_vld), 64'd0);
        chk("t6 rst busy", 64'(pb_busy), 64'd0);
        chk("t6 rst done", 64'(pb_done), 64'd0);
        chk("t6 rst loopcnt", 64'(pb_loop_cnt), 64'd0);
        chk("t6 rst data", 64'(pb_data), 64'd0);
        rst = 1'b0;
        pb_mode = 2'b00;
        tick;
        for (int e = 0; e < 5; e++) rd_chk(e, e % 2, "t6 mem intact");
        rd_chk(200, 1, "t6 mem intact hi");
        oldv = model[7];
        wr_en = 1'b1;
        wr_addr = ADDR_W'(7 * 2 + 1);
        wr_data = ~oldv[63:32];
        rd_en = 1'b1;
        rd_addr = ADDR_W'(7 * 2 + 1);
        tick;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rd-first old", 64'(rd_data), 64'(oldv[63:32]));
        model[7][63:32] = ~oldv[63:32];
        rd_chk(7, 1, "rd-first new");
        pb_mode = 2'b10;
        pb_len = 9'd3;
        pb_ready = 1'b1;
        pb_start = 1'b1;
        tick;
        pb_start = 1'b0;
        tick;
        oldv = pay(1);
        neww = model[1][31:0] ^ 32'h5A5A0001;
        wr_en = 1'b1;
        wr_addr = ADDR_W'(1 * 2);
        wr_data = neww;
        tick;
        wr_en = 1'b0;
        model[1][31:0] = neww;
        chk("coll old vld", 64'(pb_vld), 64'd1);
        chk("coll old data", 64'(pb_data), oldv);
        tick;
        chk("coll e2", 64'(pb_data), pay(2));
        tick;
        chk("coll e0", 64'(pb_data), pay(0));
        tick;
        chk("coll new vld", 64'(pb_vld), 64'd1);
        chk("coll new data", 64'(pb_data), pay(1));
        pb_mode = 2'b00;
        tick;
        chk("coll abort vld", 64'(pb_vld), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
